controller_emulator: RTL and testbench
======================================

Name: controller_emulator

Overview:
- Device-side end of the serial game-controller link: emulates an 8-bit parallel-in/serial-out controller inside logic.
- Button state from an on-chip source (debug UART, network bridge, replay engine) is presented to a host controller interface over the standard controller_clk / controller_latch / active-low data wire.
- Fully synchronous to the local clock. External host strobes are synchronized and edge-detected, never used as clocks.

Parameters:
- N_BITS, 8, number of button bits per frame.
- SYNC_STAGES, 2, flip-flop stages on controller_clk and controller_latch synchronizers (min 2).
- FILL_B, 1'b1, level shifted into data_B after all N_BITS bits have been read.

Ports:
- clk  input  1  local clock; all state on rising edge.
- rst  input  1  asynchronous active-high reset.
- buttons_in  input  N_BITS  button state, 1 = pressed; bit 0 sent first.
- controller_clk  input  1  host shift clock, asynchronous to clk.
- controller_latch  input  1  host latch, asynchronous to clk, active-high.
- controller_data_B  output  1  serial data, active-low (0 = pressed).
- latch_strobe  output  1  one-cycle pulse on synchronized latch falling edge.
- frame_done  output  1  one-cycle pulse when bit count reaches N_BITS.
- bit_count  output  $clog2(N_BITS+1)  bits shifted since last latch, saturating at N_BITS.

Behaviour:
- Reset (async assert, sync release):
  - shift register all 1s; controller_data_B = 1.
  - bit_count = 0; latch_strobe = 0; frame_done = 0.
  - synchronizer flops = 0; armed = 0.
- Synchronization:
  - controller_clk and controller_latch each pass through SYNC_STAGES flops, then one edge-detect register.
  - Latency from external edge to effect: SYNC_STAGES+1 clk cycles.
  - Host must hold each clk/latch level at least SYNC_STAGES+2 clk cycles.
- armed flag:
  - Clear after reset; set on the first synchronized latch-high cycle; never clears except by reset.
  - While armed = 0, clk edges are ignored and data_B stays 1. This suppresses the spurious edge when the host idles clk high.
- Latch high (synchronized):
  - Every cycle, shift register loads ~buttons_in (stored active-low); bit_count = 0.
  - controller_data_B = ~buttons_in[0], registered, 1 cycle after load.
  - clk edges are ignored.
- Latch falling edge:
  - latch_strobe = 1 for one cycle.
  - The shift register keeps the value loaded in the last latch-high cycle, so buttons_in changes afterwards do not affect the frame.
- controller_clk rising edge (synchronized), latch low, armed = 1:
  - Shift right one; MSB fills with FILL_B; data_B takes the new bit 0 on the same edge.
  - bit_count increments, saturating at N_BITS.
- On the shift where bit_count goes N_BITS-1 -> N_BITS: frame_done = 1 for one cycle.
- Further edges keep shifting FILL_B; bit_count stays N_BITS; no further frame_done.
- Simultaneous synchronized latch-high and clk rising edge: latch wins, load only, no shift.
- Latch asserted mid-frame: frame aborted; reload; bit_count = 0; no frame_done.
- Reset mid-frame: all state to reset values immediately; armed cleared.
- controller_clk falling edges have no effect.

Optional Feature:
- Macro: CONTROLLER_EMULATOR_TURBO_EN
- Defined:
  - Adds input turbo_mask [N_BITS-1:0] and parameter TURBO_PERIOD (default 4).
  - A frame counter counts latch falling edges, modulo 2*TURBO_PERIOD; reset value 0.
  - Any bit with turbo_mask = 1 loads as pressed only while counter < TURBO_PERIOD, otherwise released.
  - Bits with turbo_mask = 0 load unchanged.
- Undefined: turbo_mask port and counter absent; buttons_in loads directly.

Test Plan:
- Basic frame: buttons_in = 8'b11111110.
  - Latch 9 cycles, then 8 clk pulses (each level 4 cycles).
  - data_B sequence bit0..7 = 1,0,0,0,0,0,0,0.
  - frame_done pulses once after the 8th rising edge; bit_count = 8.
- Overrun: after the above frame, 3 extra clk pulses -> data_B = FILL_B (1) each; bit_count holds 8; no frame_done.
- Pre-arm: release reset with controller_clk = 1, toggle clk 4 times with no latch -> data_B stays 1; bit_count stays 0.
- Mid-frame latch: buttons_in = 8'h81.
  - Shift 3 bits, then latch with buttons_in = 8'h7F.
  - bit_count resets to 0; next frame reads bit0..7 = 1,1,1,1,1,1,1,0 pressed, i.e. data_B = 0,0,0,0,0,0,0,1.
- Post-latch stability: latch with 8'h01, change buttons_in to 8'hFF after latch falls -> frame still reads only bit 0 pressed.
- Turbo (macro defined): turbo_mask = 8'h01, buttons_in = 8'h01, TURBO_PERIOD = 4, 8 frames.
  - Bit 0 reads pressed in frames 0-3, released in frames 4-7.
  - latch_strobe pulses 8 times.

Source files
------------

// File: rtl/controller_emulator.sv
// controller_emulator: device side of a serial game-controller link (latch/clk in, active-low data out); optional turbo via CONTROLLER_EMULATOR_TURBO_EN
//   ports: clk, rst (async high), buttons_in[N_BITS] (1 = pressed, bit 0 first), controller_clk, controller_latch,
//          controller_data_B (0 = pressed), latch_strobe, frame_done, bit_count; turbo_mask when the macro is defined
module controller_emulator #(
  parameter int   N_BITS      = 8,
  parameter int   SYNC_STAGES = 2,
  parameter logic FILL_B      = 1'b1
`ifdef CONTROLLER_EMULATOR_TURBO_EN
  ,
  parameter int   TURBO_PERIOD = 4
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_BITS-1:0]             buttons_in,
`ifdef CONTROLLER_EMULATOR_TURBO_EN
  input  logic [N_BITS-1:0]             turbo_mask,
`endif
  input  logic                          controller_clk,
  input  logic                          controller_latch,
  output logic                          controller_data_B,
  output logic                          latch_strobe,
  output logic                          frame_done,
  output logic [$clog2(N_BITS+1)-1:0]   bit_count
);
  localparam int CW = $clog2(N_BITS+1);
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, latch_sync_q, latch_sync_d;
  logic                   clk_prev_q, latch_prev_q, armed_q, armed_d;
  logic                   latch_strobe_q, latch_strobe_d, frame_done_q, frame_done_d;
  logic [N_BITS-1:0]      shift_q, shift_d, load_val;
  logic [CW-1:0]          bit_count_q, bit_count_d;
  logic                   clk_s, latch_s, clk_rise, latch_fall, shift;
`ifdef CONTROLLER_EMULATOR_TURBO_EN
  localparam int TW = $clog2(2*TURBO_PERIOD) > 0 ? $clog2(2*TURBO_PERIOD) : 1;
  logic [TW-1:0] frame_cnt_q, frame_cnt_d;
  // turbo bits are gated off during the second half of each 2*TURBO_PERIOD frame cycle
  always_comb begin
    load_val    = buttons_in & ~(turbo_mask & {N_BITS{frame_cnt_q >= TW'(TURBO_PERIOD)}});
    frame_cnt_d = !latch_fall ? frame_cnt_q : (frame_cnt_q == TW'(2*TURBO_PERIOD-1)) ? '0 : frame_cnt_q + 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) frame_cnt_q <= '0;
    else     frame_cnt_q <= frame_cnt_d;
`else
  assign load_val = buttons_in;
`endif
  assign clk_s    = clk_sync_q[SYNC_STAGES-1];
  assign latch_s  = latch_sync_q[SYNC_STAGES-1];
  assign clk_rise   = clk_s & ~clk_prev_q;
  assign latch_fall = ~latch_s & latch_prev_q;
  // clk edges only count once a latch has been seen, so an idle-high clk at power-up is not a shift
  assign shift    = clk_rise & ~latch_s & armed_q;
  always_comb begin
    clk_sync_d     = {clk_sync_q[SYNC_STAGES-2:0], controller_clk};
    latch_sync_d   = {latch_sync_q[SYNC_STAGES-2:0], controller_latch};
    armed_d        = armed_q | latch_s;
    latch_strobe_d = latch_fall;
    frame_done_d   = shift && bit_count_q == CW'(N_BITS-1);
    shift_d        = latch_s ? ~load_val : shift ? {FILL_B, shift_q[N_BITS-1:1]} : shift_q;
    bit_count_d    = latch_s ? '0 : (shift && bit_count_q != CW'(N_BITS)) ? bit_count_q + 1'b1 : bit_count_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      clk_sync_q     <= '0;
      latch_sync_q   <= '0;
      clk_prev_q     <= 1'b0;
      latch_prev_q   <= 1'b0;
      armed_q        <= 1'b0;
      latch_strobe_q <= 1'b0;
      frame_done_q   <= 1'b0;
      shift_q        <= '1;
      bit_count_q    <= '0;
    end else begin
      clk_sync_q     <= clk_sync_d;
      latch_sync_q   <= latch_sync_d;
      clk_prev_q     <= clk_s;
      latch_prev_q   <= latch_s;
      armed_q        <= armed_d;
      latch_strobe_q <= latch_strobe_d;
      frame_done_q   <= frame_done_d;
      shift_q        <= shift_d;
      bit_count_q    <= bit_count_d;
    end
  assign controller_data_B = shift_q[0];
  assign latch_strobe      = latch_strobe_q;
  assign frame_done        = frame_done_q;
  assign bit_count         = bit_count_q;
endmodule

// File: tb/tb_controller_emulator.sv
// tb_controller_emulator: directed self-checking bench for controller_emulator
module tb_controller_emulator;
  logic       clk = 1'b0, rst = 1'b1;
  logic [7:0] buttons_in = 8'h00;
  logic       controller_clk = 1'b0, controller_latch = 1'b0;
  logic       controller_data_B, latch_strobe, frame_done;
  logic [3:0] bit_count;
`ifdef CONTROLLER_EMULATOR_TURBO_EN
  logic [7:0] turbo_mask = 8'h00;
`endif
  int tests = 0, fails = 0, fd_cnt = 0, ls_cnt = 0;
  controller_emulator dut (
    .clk(clk), .rst(rst), .buttons_in(buttons_in),
`ifdef CONTROLLER_EMULATOR_TURBO_EN
    .turbo_mask(turbo_mask),
`endif
    .controller_clk(controller_clk), .controller_latch(controller_latch),
    .controller_data_B(controller_data_B), .latch_strobe(latch_strobe),
    .frame_done(frame_done), .bit_count(bit_count)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (latch_strobe) ls_cnt++;
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input logic cval);
    controller_clk = cval; controller_latch = 1'b0;
    rst = 1'b1; cyc(2); rst = 1'b0; cyc(1);
  endtask
  task automatic latch(input logic [7:0] b);
    buttons_in = b; controller_latch = 1'b1; cyc(9);
    controller_latch = 1'b0; cyc(5);
  endtask
  task automatic pulse();
    controller_clk = 1'b1; cyc(4);
    controller_clk = 1'b0; cyc(4);
  endtask
  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic read_frame(input string nm, input logic [7:0] b);
    chk({nm, " bit0"}, {3'b0, controller_data_B}, {3'b0, ~b[0]});
    for (int i = 1; i < 8; i++) begin
      pulse();
      chk($sformatf("%s bit%0d", nm, i), {3'b0, controller_data_B}, {3'b0, ~b[i]});
      chk($sformatf("%s count%0d", nm, i), bit_count, 4'(i));
    end
  endtask
  task automatic test_reset();
    rst = 1'b1; cyc(2);
    chk("reset data_B", {3'b0, controller_data_B}, 4'd1);
    chk("reset bit_count", bit_count, 4'd0);
    chk("reset strobes", {2'b0, latch_strobe, frame_done}, 4'd0);
  endtask
  task automatic test_pre_arm();
    do_reset(1'b1); cyc(4);
    controller_clk = 1'b0; cyc(4);
    repeat (4) pulse();
    chk("prearm data_B", {3'b0, controller_data_B}, 4'd1);
    chk("prearm bit_count", bit_count, 4'd0);
  endtask
  task automatic test_basic_frame();
    int f0, l0;
    l0 = ls_cnt;
    latch(8'b11111110);
    chk("basic strobe", 4'(ls_cnt - l0), 4'd1);
    chk("basic count0", bit_count, 4'd0);
    f0 = fd_cnt;
    read_frame("basic", 8'b11111110);
    chk("basic no early done", 4'(fd_cnt - f0), 4'd0);
    pulse();
    chk("basic done", 4'(fd_cnt - f0), 4'd1);
    chk("basic count8", bit_count, 4'd8);
  endtask
  task automatic test_overrun();
    int f0;
    f0 = fd_cnt;
    for (int i = 0; i < 3; i++) begin
      pulse();
      chk("overrun data_B", {3'b0, controller_data_B}, 4'd1);
      chk("overrun count", bit_count, 4'd8);
    end
    chk("overrun no done", 4'(fd_cnt - f0), 4'd0);
  endtask
  task automatic test_mid_frame_latch();
    int f0;
    latch(8'h81);
    repeat (3) pulse();
    chk("mid count3", bit_count, 4'd3);
    f0 = fd_cnt;
    latch(8'h7F);
    chk("mid count reset", bit_count, 4'd0);
    read_frame("mid", 8'h7F);
    pulse();
    chk("mid done", 4'(fd_cnt - f0), 4'd1);
  endtask
  task automatic test_post_latch_stability();
    latch(8'h01);
    buttons_in = 8'hFF; cyc(2);
    read_frame("stable", 8'h01);
  endtask
  task automatic test_latch_wins();
    buttons_in = 8'h02;
    controller_latch = 1'b1; controller_clk = 1'b1; cyc(9);
    chk("latchwins count", bit_count, 4'd0);
    chk("latchwins data_B", {3'b0, controller_data_B}, 4'd1);
    controller_latch = 1'b0; cyc(5);
    controller_clk = 1'b0; cyc(4);
    chk("latchwins no shift", bit_count, 4'd0);
    pulse();
    chk("latchwins bit1", {3'b0, controller_data_B}, 4'd0);
  endtask
  task automatic test_reset_mid_frame();
    latch(8'h00);
    repeat (2) pulse();
    chk("rstmid count2", bit_count, 4'd2);
    do_reset(1'b0);
    chk("rstmid count", bit_count, 4'd0);
    chk("rstmid data_B", {3'b0, controller_data_B}, 4'd1);
    pulse();
    chk("rstmid disarmed", bit_count, 4'd0);
  endtask
`ifdef CONTROLLER_EMULATOR_TURBO_EN
  task automatic test_turbo();
    int l0;
    do_reset(1'b0);
    turbo_mask = 8'h01;
    l0 = ls_cnt;
    for (int i = 0; i < 8; i++) begin
      latch(8'h01);
      chk($sformatf("turbo frame%0d", i), {3'b0, controller_data_B}, i < 4 ? 4'd0 : 4'd1);
    end
    chk("turbo strobes", 4'(ls_cnt - l0), 4'd8);
    turbo_mask = 8'h00;
  endtask
`endif
  initial begin
    test_reset();
    test_pre_arm();
    test_basic_frame();
    test_overrun();
    test_mid_frame_latch();
    test_post_latch_stability();
    test_latch_wins();
    test_reset_mid_frame();
`ifdef CONTROLLER_EMULATOR_TURBO_EN
    test_turbo();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
